// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits are served in the same cycle; read misses and all writes stall the core while main memory responds.
module data_cache_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RFILL = 2'd1,
    S_WTHRU = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic [ADDR_W-1:0]   w_word_addr;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_fill;
  logic                w_wr_update;
  logic                w_cnt_hit;
  logic                w_cnt_miss;
  logic                w_unused;

  assign w_word_addr = Addr[ADDR_W+1:2];
  assign w_index     = w_word_addr[INDEX_W-1:0];
  assign w_tag       = w_word_addr[ADDR_W-1:INDEX_W];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused    = ^{Addr[31:ADDR_W+2], Addr[1:0]};

  // The core holds Addr/WrData stable during a stall, so the memory bus is driven straight from them.
  assign mem_addr  = w_word_addr;
  assign mem_wdata = WrData;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, handshake outputs and array/counter update strobes.
  always_comb begin
    w_next      = r_state;
    Stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    RdData      = '0;
    w_fill      = 1'b0;
    w_wr_update = 1'b0;
    w_cnt_hit   = 1'b0;
    w_cnt_miss  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (MemWrite) begin
            Stall  = 1'b1;
            w_next = S_WTHRU;
          end else if (MemRead) begin
            if (w_hit) begin
              RdData    = r_data[w_index];
              w_cnt_hit = 1'b1;
            end else begin
              Stall      = 1'b1;
              w_cnt_miss = 1'b1;
              w_next     = S_RFILL;
            end
          end
        end
        S_RFILL: begin
          mem_req = 1'b1;
          Stall   = !mem_ready;
          if (mem_ready) begin
            RdData = mem_rdata;
            w_fill = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_WTHRU: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          Stall   = !mem_ready;
          if (mem_ready) begin
            w_wr_update = w_hit;
            w_next      = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Valid bits and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_fill) r_valid[w_index] <= 1'b1;
      if (w_cnt_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_cnt_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_rdata;
    end else if (w_wr_update) begin
      r_data[w_index] <= WrData;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: miss fill, hit, write-through, no-allocate,
// conflict eviction and reset in the middle of a fill.
module tb_data_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  data_cache_ctrl #(
    .ADDR_W (10),
    .INDEX_W(5),
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .Stall    (Stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, well away from the clock edge.
  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  // Read that must miss: one IDLE stall cycle, then memory answers on the first RFILL cycle.
  task automatic read_miss(input logic [31:0] a, input logic [31:0] d, input string tag);
    MemRead = 1'b1;
    Addr    = a;
    settle();
    chk({tag, "_stall"}, 32'(Stall), 32'd1);
    tick();
    settle();
    chk({tag, "_addr"}, 32'(mem_addr), a >> 2);
    mem_ready = 1'b1;
    mem_rdata = d;
    settle();
    chk({tag, "_rdata"}, RdData, d);
    tick();
    idle_inputs();
  endtask

  initial begin
    rst      = 1'b1;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Addr     = 32'h40;
    WrData   = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    // Reset forces the handshake outputs low even with a strobe present.
    tick();
    settle();
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", RdData, 32'h0);
    tick();
    settle();
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    rst = 1'b0;

    // 1) read miss at 0x40; memory answers on the third cycle after the request.
    MemRead = 1'b1;
    Addr    = 32'h40;
    settle();
    chk("t1_c0_stall", 32'(Stall), 32'd1);
    chk("t1_c0_req", 32'(mem_req), 32'd0);
    tick();
    settle();
    chk("t1_c1_stall", 32'(Stall), 32'd1);
    chk("t1_c1_req", 32'(mem_req), 32'd1);
    chk("t1_c1_we", 32'(mem_we), 32'd0);
    chk("t1_c1_addr", 32'(mem_addr), 32'h10);
    chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);
    tick();
    settle();
    chk("t1_c2_stall", 32'(Stall), 32'd1);
    chk("t1_c2_req", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_c3_stall", 32'(Stall), 32'd0);
    chk("t1_c3_rdata", RdData, 32'hDEADBEEF);
    tick();
    idle_inputs();
    settle();
    chk("t1_idle_stall", 32'(Stall), 32'd0);
    chk("t1_idle_req", 32'(mem_req), 32'd0);
    chk("t1_idle_rdata", RdData, 32'h0);

    // 2) repeat read hits in the same cycle.
    MemRead = 1'b1;
    Addr    = 32'h40;
    settle();
    chk("t2_stall", 32'(Stall), 32'd0);
    chk("t2_rdata", RdData, 32'hDEADBEEF);
    tick();
    idle_inputs();
    settle();
    chk("t2_hit_cnt", 32'(hit_cnt), 32'd1);

    // 3) write hit to 0x40 with both strobes high: the write wins, ready after 2 cycles.
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    Addr     = 32'h40;
    WrData   = 32'h12345678;
    settle();
    chk("t3_c0_stall", 32'(Stall), 32'd1);
    chk("t3_c0_rdata", RdData, 32'h0);
    tick();
    settle();
    chk("t3_hit_cnt", 32'(hit_cnt), 32'd1);
    chk("t3_c1_req", 32'(mem_req), 32'd1);
    chk("t3_c1_we", 32'(mem_we), 32'd1);
    chk("t3_c1_addr", 32'(mem_addr), 32'h10);
    chk("t3_c1_wdata", mem_wdata, 32'h12345678);
    chk("t3_c1_stall", 32'(Stall), 32'd1);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("t3_c2_stall", 32'(Stall), 32'd0);
    chk("t3_c2_we", 32'(mem_we), 32'd1);
    tick();
    idle_inputs();
    MemRead = 1'b1;
    settle();
    chk("t3_rd_stall", 32'(Stall), 32'd0);
    chk("t3_rd_rdata", RdData, 32'h12345678);
    tick();
    idle_inputs();
    settle();
    chk("t3_hit_cnt2", 32'(hit_cnt), 32'd2);

    // 4) write miss to 0x80 goes to memory but does not allocate.
    MemWrite = 1'b1;
    Addr     = 32'h80;
    WrData   = 32'hCAFEF00D;
    settle();
    chk("t4_w_stall", 32'(Stall), 32'd1);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("t4_w_we", 32'(mem_we), 32'd1);
    chk("t4_w_addr", 32'(mem_addr), 32'h20);
    chk("t4_w_wdata", mem_wdata, 32'hCAFEF00D);
    chk("t4_w_stall_done", 32'(Stall), 32'd0);
    tick();
    idle_inputs();
    read_miss(32'h80, 32'h0BADF00D, "t4_rd");
    settle();
    chk("t4_miss_cnt", 32'(miss_cnt), 32'd2);
    MemRead = 1'b1;
    Addr    = 32'h80;
    settle();
    chk("t4_rehit_stall", 32'(Stall), 32'd0);
    chk("t4_rehit_rdata", RdData, 32'h0BADF00D);
    tick();
    idle_inputs();

    // 5) fresh reset, then 0x40 / 0xC0 / 0x40 fight over one line: three misses.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_hit_clr", 32'(hit_cnt), 32'd0);
    chk("t5_miss_clr", 32'(miss_cnt), 32'd0);
    read_miss(32'h40, 32'h11111111, "t5_a");
    read_miss(32'hC0, 32'h22222222, "t5_b");
    read_miss(32'h40, 32'h33333333, "t5_c");
    settle();
    chk("t5_miss_cnt", 32'(miss_cnt), 32'd3);
    chk("t5_hit_cnt", 32'(hit_cnt), 32'd0);
    MemRead = 1'b1;
    Addr    = 32'h40;
    settle();
    chk("t5_final_rdata", RdData, 32'h33333333);
    tick();
    idle_inputs();

    // 6) reset while a fill is outstanding; the coincident mem_ready must be ignored.
    MemRead = 1'b1;
    Addr    = 32'hC0;
    settle();
    chk("t6_stall", 32'(Stall), 32'd1);
    tick();
    settle();
    chk("t6_rfill_req", 32'(mem_req), 32'd1);
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h44444444;
    settle();
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    chk("t6_rst_stall", 32'(Stall), 32'd0);
    chk("t6_rst_rdata", RdData, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    chk("t6_post_req", 32'(mem_req), 32'd0);
    chk("t6_post_stall", 32'(Stall), 32'd0);
    read_miss(32'h40, 32'h55555555, "t6_rd");
    settle();
    chk("t6_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("t6_hit_cnt", 32'(hit_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
